// File: rtl/k007452_div_seq.sv
// Control sequencer for the 007452 16/16 restoring serial divider: register decode,
// start/restart handling, per-bit trial/commit strobes and divide-by-zero forcing.
module k007452_div_seq #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned START_ADDR = 5
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [2:0] ab_l_i,
   input  logic       wr_stb_i,
   input  logic       rd_stb_i,
   input  logic       div_zero_i,
   input  logic       trial_ok_i,
   output logic [3:0] op_we_o,
   output logic       ld_op_o,
   output logic       shift_en_o,
   output logic       sub_en_o,
   output logic       res_we_o,
   output logic       force_dz_o,
   output logic [1:0] rd_sel_o,
   output logic       rd_valid_o,
   output logic       busy_o
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {StIdle, StLoad, StTrial, StCommit, StLatch} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            dz_q, dz_d;
   logic            ld_op_q, shift_q, res_we_q, force_dz_q, busy_q;
   logic            start;
   logic            in_range;

   assign start    = wr_stb_i && (ab_l_i == 3'(START_ADDR));
   assign in_range = (ab_l_i >= 3'd2) && (ab_l_i <= 3'd5);

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         op_we_o[n] = wr_stb_i && (ab_l_i == 3'(n + 2));
      end
   end

   // Address 2..5 maps to select 0..3 by its low two bits minus two.
   assign rd_sel_o   = in_range ? (ab_l_i[1:0] - 2'd2) : 2'd0;
   assign rd_valid_o = rd_stb_i && in_range;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      unique case (state_q)
         StIdle: ;
         StLoad: begin
            cnt_d   = CntW'(WIDTH - 1);
            dz_d    = div_zero_i;
            state_d = StTrial;
         end
         StTrial:  state_d = StCommit;
         StCommit: begin
            if (cnt_q == '0) begin
               state_d = StLatch;
            end else begin
               cnt_d   = cnt_q - CntW'(1);
               state_d = StTrial;
            end
         end
         StLatch:  state_d = StIdle;
         default:  state_d = StIdle;
      endcase
      // A start write always wins, including mid-run and during the latch cycle.
      if (start) begin
         state_d = StLoad;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         dz_q       <= 1'b0;
         ld_op_q    <= 1'b0;
         shift_q    <= 1'b0;
         res_we_q   <= 1'b0;
         force_dz_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dz_q       <= dz_d;
         ld_op_q    <= (state_d == StLoad);
         shift_q    <= (state_d == StTrial);
         res_we_q   <= (state_d == StLatch);
         force_dz_q <= (state_d == StLatch) && dz_d;
         busy_q     <= (state_d != StIdle);
      end
   end

   assign ld_op_o    = ld_op_q;
   assign shift_en_o = shift_q;
   assign res_we_o   = res_we_q;
   assign force_dz_o = force_dz_q;
   assign busy_o     = busy_q;
   // Trial result arrives combinationally from the datapath within the commit cycle.
   assign sub_en_o   = (state_q == StCommit) && trial_ok_i && !dz_q;

endmodule

// File: tb/tb_k007452_div_seq.sv
// Bench for k007452_div_seq: behavioural shift-subtract datapath driven by the DUT strobes,
// results checked through the read mux against arithmetic expectations from a scoreboard.
module tb_k007452_div_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] ab = 3'd0;
   logic       wr_stb = 1'b0;
   logic       rd_stb = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic       div_zero, trial_ok;
   logic [3:0] op_we;
   logic       ld_op, shift_en, sub_en, res_we, force_dz, rd_valid, busy;
   logic [1:0] rd_sel;

   k007452_div_seq #(.WIDTH(16), .START_ADDR(5)) dut (
      .clk_i(clk), .rst_i(rst), .ab_l_i(ab), .wr_stb_i(wr_stb), .rd_stb_i(rd_stb),
      .div_zero_i(div_zero), .trial_ok_i(trial_ok), .op_we_o(op_we), .ld_op_o(ld_op),
      .shift_en_o(shift_en), .sub_en_o(sub_en), .res_we_o(res_we), .force_dz_o(force_dz),
      .rd_sel_o(rd_sel), .rd_valid_o(rd_valid), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // Datapath model: operand bytes 0=divisor hi, 1=divisor lo, 2=dividend hi, 3=dividend lo.
   logic [7:0]  opr [4];
   logic [16:0] r_w;
   logic [15:0] q_w, q_res, r_res;
   logic [15:0] divisor, dividend;
   logic [7:0]  rd_data;

   initial begin
      for (int i = 0; i < 4; i++) opr[i] = 8'h00;
      r_w = '0; q_w = '0; q_res = '0; r_res = '0;
   end

   assign divisor  = {opr[0], opr[1]};
   assign dividend = {opr[2], opr[3]};
   assign div_zero = (divisor == 16'h0000);
   assign trial_ok = (r_w >= {1'b0, divisor});

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) if (op_we[i]) opr[i] <= wdata;
      if (ld_op) begin
         q_w <= dividend;
         r_w <= '0;
      end else if (shift_en) begin
         {r_w, q_w} <= {r_w[15:0], q_w, 1'b0};
      end else if (sub_en) begin
         r_w    <= r_w - {1'b0, divisor};
         q_w[0] <= 1'b1;
      end
      if (res_we) begin
         q_res <= force_dz ? 16'hFFFF : q_w;
         r_res <= force_dz ? 16'h0000 : r_w[15:0];
      end
   end

   always_comb begin
      case (rd_sel)
         2'd3:    rd_data = q_res[15:8];
         2'd2:    rd_data = q_res[7:0];
         2'd1:    rd_data = r_res[15:8];
         default: rd_data = r_res[7:0];
      endcase
   end

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   logic [31:0] sb [$];
   logic [15:0] prev_q = 16'h0000;
   logic [15:0] prev_r = 16'h0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] expect_qr(input logic [15:0] a, input logic [15:0] b);
      if (a == 16'h0000) return {16'hFFFF, 16'h0000};
      return {b / a, b % a};
   endfunction

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      ab = a; wdata = d; wr_stb = 1'b1;
      @(negedge clk);
      wr_stb = 1'b0; ab = 3'd0;
   endtask

   // Called at a negedge; leaves inputs idle at the following negedge.
   task automatic rd(input logic [2:0] a, output logic [7:0] d);
      ab = a; rd_stb = 1'b1;
      #1;
      check("rd_valid", rd_valid, 1);
      check("rd_sel", rd_sel, 32'(a) - 32'd2);
      d = rd_data;
      @(negedge clk);
      rd_stb = 1'b0; ab = 3'd0;
   endtask

   task automatic read_result(output logic [15:0] q, output logic [15:0] r);
      logic [7:0] b3, b2, b1, b0;
      rd(3'd5, b3); rd(3'd4, b2); rd(3'd3, b1); rd(3'd2, b0);
      q = {b3, b2};
      r = {b1, b0};
   endtask

   task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
      wr(3'd2, a[15:8]); wr(3'd3, a[7:0]); wr(3'd4, b[15:8]);
   endtask

   // Start write on dividend lo; optional restart (new dividend lo) and busy read at given cycles.
   task automatic run_div(input logic [15:0] a, input logic [15:0] b, input int restart_k,
                          input logic [7:0] new_lo, input int rd_k);
      int k, ld_k, res_k, nres, shifts, subs, base;
      logic fdz, done;
      logic [15:0] q, r;
      logic [31:0] exp;
      ld_k = 0; res_k = 0; nres = 0; shifts = 0; subs = 0; fdz = 1'b0; done = 1'b0;
      sb.push_back(expect_qr(a, b));
      wr(3'd5, b[7:0]);
      k = 1;
      while (k <= 120 && !done) begin
         if (ld_op && ld_k == 0) ld_k = k;
         if (shift_en) shifts++;
         if (sub_en) subs++;
         if (res_we) begin nres++; res_k = k; fdz = force_dz; end
         if (!busy) begin
            done = 1'b1;
         end else begin
            if (k == restart_k) begin
               ab = 3'd5; wdata = new_lo; wr_stb = 1'b1;
               void'(sb.pop_back());
               sb.push_back(expect_qr(a, {b[15:8], new_lo}));
               b = {b[15:8], new_lo};
            end else if (k == rd_k) begin
               ab = 3'd4; rd_stb = 1'b1;
               #1;
               check("busy_rd_valid", rd_valid, 1);
               check("busy_rd_sel", rd_sel, 2);
               check("busy_rd_data", rd_data, prev_q[7:0]);
            end else begin
               ab = 3'd0; wr_stb = 1'b0; rd_stb = 1'b0;
            end
            @(negedge clk);
            ab = 3'd0; wr_stb = 1'b0; rd_stb = 1'b0;
            k++;
         end
      end
      check("busy_timeout", done, 1);
      base = (restart_k > 0) ? restart_k : 0;
      check("res_we_cycle", res_k, base + 34);
      check("res_we_count", nres, 1);
      check("busy_low_cycle", k, base + 35);
      check("force_dz", fdz, (a == 16'h0000));
      if (restart_k == 0) begin
         exp = expect_qr(a, b);
         check("ld_op_cycle", ld_k, 1);
         check("shift_count", shifts, 16);
         check("sub_count", subs, (a == 16'h0000) ? 0 : $countones(exp[31:16]));
      end
      read_result(q, r);
      exp = sb.pop_front();
      check("quotient", q, exp[31:16]);
      check("remainder", r, exp[15:0]);
      prev_q = q;
      prev_r = r;
   endtask

   initial begin
      logic [15:0] q, r, a, b;
      repeat (2) @(negedge clk);
      #1;
      check("reset_strobes", {op_we, ld_op, shift_en, sub_en, res_we, force_dz, rd_valid}, 0);
      check("reset_rd_sel", rd_sel, 0);
      check("reset_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // Writes outside 2..5 are ignored; decode of a real operand address.
      ab = 3'd7; wdata = 8'hAA; wr_stb = 1'b1; rd_stb = 1'b1;
      #1;
      check("op_we_ab7", op_we, 4'b0000);
      check("rd_valid_ab7", rd_valid, 0);
      check("rd_sel_ab7", rd_sel, 0);
      @(negedge clk);
      wr_stb = 1'b0; rd_stb = 1'b0;
      check("no_start_ab7", busy, 0);
      ab = 3'd2; wdata = 8'h00; wr_stb = 1'b1;
      #1;
      check("op_we_ab2", op_we, 4'b0001);
      @(negedge clk);
      wr_stb = 1'b0; ab = 3'd0;

      // 1000 / 7
      load_ops(16'h0007, 16'h03E8);
      run_div(16'h0007, 16'h03E8, 0, 8'h00, 0);
      check("q_1000_7", prev_q, 16'h008E);
      check("r_1000_7", prev_r, 16'h0006);

      // Divide by zero, and divisor 1 (every commit subtracts)
      load_ops(16'h0000, 16'h1234);
      run_div(16'h0000, 16'h1234, 0, 8'h00, 0);
      load_ops(16'h0001, 16'hFFFF);
      run_div(16'h0001, 16'hFFFF, 0, 8'h00, 20);

      // Restart at cycle 10 with a new dividend low byte
      load_ops(16'h0003, 16'h0100);
      run_div(16'h0003, 16'h0100, 10, 8'h55, 0);

      // Reset mid-run: immediate idle, previous result retained
      load_ops(16'h0009, 16'h4321);
      wr(3'd5, 8'h21);
      repeat (14) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_strobes", {ld_op, shift_en, sub_en, res_we, force_dz}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_idle", busy, 0);
      read_result(q, r);
      check("midrst_q", q, prev_q);
      check("midrst_r", r, prev_r);

      // Random sweep
      for (int i = 0; i < 150; i++) begin
         a = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
         b = 16'($urandom);
         load_ops(a, b);
         run_div(a, b, 0, 8'h00, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
